// File: rtl/score_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter. It keeps the last result stable while a new conversion runs.
// Define SCORE_BCD_BLANK_EN to add the registered leading-zero `blank` output.
module score_bcd_converter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  start,
  input  logic                  auto_en,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef SCORE_BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [WIDTH-1:0]      shreg;
  logic [WIDTH-1:0]      last_bin;
  logic [4*DIGITS-1:0]   scratch;
  logic [CW-1:0]         cnt;
  logic [4*DIGITS-1:0]   adjusted;
  logic [4*DIGITS-1:0]   shifted;
  logic                  trigger;

  assign trigger = start || (auto_en && (bin_in != last_bin));

  // Per-digit +3 with no carry between digits, then shift in the next binary bit.
  always_comb begin
    adjusted = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {adjusted[4*DIGITS-2:0], shreg[WIDTH-1]};
  end

`ifdef SCORE_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_next;

  // Scan from the top digit down. A digit is blanked while every digit above it is zero, except the units digit.
  always_comb begin
    logic zero_above;
    int unsigned k;
    blank_next = '0;
    zero_above = 1'b1;
    k = 0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      k = DIGITS - 1 - i;
      zero_above = zero_above && (shifted[4*k +: 4] == 4'd0);
      blank_next[k] = zero_above && (k != 0);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      last_bin <= '0;
      cnt      <= '0;
      shreg    <= '0;
      scratch  <= '0;
`ifdef SCORE_BCD_BLANK_EN
      blank    <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            shreg    <= bin_in;
            last_bin <= bin_in;
            scratch  <= '0;
            cnt      <= CW'(WIDTH - 1);
            state    <= SHIFT;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
          if (cnt == '0) begin
            bcd_out <= shifted;
`ifdef SCORE_BCD_BLANK_EN
            blank   <= blank_next;
`endif
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter: directed table, corner sequences, random values vs decimal model.
module tb_score_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bin_in = '0;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
`ifdef SCORE_BCD_BLANK_EN
  logic [4:0]  blank;
`endif

  int checks = 0;
  int errors = 0;

  score_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bin_in  (bin_in),
    .start   (start),
    .auto_en (auto_en),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
`ifdef SCORE_BCD_BLANK_EN
    ,
    .blank   (blank)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
  } vec_t;

  // Decimal reference: peel digits off with integer division.
  function automatic logic [19:0] model_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] model_blank(input int unsigned v);
    logic [4:0] b;
    int nd;
    nd = 1;
    while (v >= 10) begin
      v = v / 10;
      nd++;
    end
    b = '0;
    for (int i = 0; i < 5; i++) b[i] = (i >= nd);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // If `now` is set, the caller is already inside the done-high cycle and the trigger goes in without waiting.
  task automatic convert(input logic [15:0] v, input bit now,
                         output int lat, output int busy_n, output int dones);
    if (!now) @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    lat    = 1;
    busy_n = int'(busy);
    dones  = int'(done);
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      busy_n += int'(busy);
      dones  += int'(done);
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      n += int'(done);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int lat, bn, dn, extra;
    logic [15:0] v;

    vecs[0] = '{16'd0,     20'h00000};
    vecs[1] = '{16'd65535, 20'h65535};
    vecs[2] = '{16'd1234,  20'h01234};
    vecs[3] = '{16'd99,    20'h00099};
    vecs[4] = '{16'd500,   20'h00500};
    vecs[5] = '{16'd9999,  20'h09999};
    vecs[6] = '{16'd10000, 20'h10000};
    vecs[7] = '{16'd59999, 20'h59999};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_bcd", bcd_out, 0);
`ifdef SCORE_BCD_BLANK_EN
    check("reset_blank", blank, 5'b11110);
`endif
    @(negedge clk);
    rst_n   = 1'b1;
    auto_en = 1'b1;
    count_dones(6, dn);
    check("auto_zero_no_start", dn, 0);
    check("auto_zero_busy", busy, 0);
    auto_en = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].bin, 1'b0, lat, bn, dn);
      check("tbl_latency", lat, 17);
      check("tbl_busy_cycles", bn, 16);
      check("tbl_bcd", bcd_out, vecs[i].bcd);
`ifdef SCORE_BCD_BLANK_EN
      check("tbl_blank", blank, model_blank(vecs[i].bin));
`endif
      @(posedge clk); #1;
      check("tbl_done_pulse", done, 0);
    end

    // A start raised mid-conversion is ignored.
    @(negedge clk);
    bin_in = 16'd1234; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dn = int'(done);
    repeat (4) begin @(posedge clk); #1; dn += int'(done); end
    @(negedge clk); bin_in = 16'd99; start = 1'b1;
    @(negedge clk); start = 1'b0;
    count_dones(40, extra);
    check("ignore_start_dones", dn + extra, 1);
    check("ignore_start_bcd", bcd_out, 20'h01234);

    // Auto mode with bin_in 7, 8, 8 gives two conversions.
    @(negedge clk);
    bin_in = 16'd7; auto_en = 1'b1;
    count_dones(25, dn);
    check("auto7_bcd", bcd_out, 20'h00007);
    @(negedge clk); bin_in = 16'd8;
    count_dones(25, extra);
    check("auto8_bcd", bcd_out, 20'h00008);
    count_dones(40, bn);
    check("auto_total_dones", dn + extra + bn, 2);
    auto_en = 1'b0;

    // Reset mid-conversion aborts without a done pulse.
    @(negedge clk);
    bin_in = 16'd4321; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    count_dones(9, dn);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_done_seen", dn + int'(done), 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_bcd", bcd_out, 0);
    @(negedge clk); rst_n = 1'b1;
    convert(16'd4321, 1'b0, lat, bn, dn);
    check("after_rst_latency", lat, 17);
    check("after_rst_bcd", bcd_out, 20'h04321);

    // A start in the done-high cycle runs back-to-back.
    convert(16'd321, 1'b0, lat, bn, dn);
    check("b2b_first_done", done, 1);
    convert(16'd500, 1'b1, lat, bn, dn);
    check("b2b_latency", lat, 17);
    check("b2b_bcd", bcd_out, 20'h00500);

    // Random values, with start and auto trigger sometimes landing together.
    for (int i = 0; i < 40; i++) begin
      v = 16'($urandom_range(0, 65535));
      @(negedge clk);
      auto_en = 1'($urandom_range(0, 1));
      convert(v, 1'b1, lat, bn, dn);
      check("rnd_latency", lat, 17);
      check("rnd_bcd", bcd_out, model_bcd(v));
`ifdef SCORE_BCD_BLANK_EN
      check("rnd_blank", blank, model_blank(v));
`endif
      count_dones(3, extra);
      check("rnd_single_conv", dn + extra, 1);
    end
    auto_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/score_bcd_converter.md
# score_bcd_converter

Sequential binary-to-BCD converter (shift-add-3 / double-dabble) between the game logic and the seven-segment scan stage. Takes the binary score word from `block_controller` and produces decimal digits for the SSD mux, so the display shows decimal instead of hex. Runs on the system clock. Holds its last result stable while a new conversion is in progress, so the scanned digits never flicker.

## Interface
Parameters:
- `WIDTH`, default 16: binary input width.
- `DIGITS`, default 5: BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH−1.

Ports:
- `clk` in, 1: system clock; all logic on the rising edge.
- `rst_n` in, 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `bin_in` in, WIDTH: binary value to convert; sampled only at load.
- `start` in, 1: request a conversion; honoured only in IDLE.
- `auto_en` in, 1: when 1, the block self-starts whenever `bin_in` differs from the last loaded value.
- `busy` out, 1: high while in SHIFT.
- `done` out, 1: one-cycle pulse when `bcd_out` has just been updated.
- `bcd_out` out, 4*DIGITS: packed BCD; digit i is at [4i+3:4i], and digit 0 is the units digit.

## Operation
- FSM states:
  - IDLE: wait for a trigger. A trigger is `start`=1, or `auto_en`=1 with `bin_in` != `last_bin`.
  - SHIFT: perform WIDTH iterations, then return to IDLE.
- Load (IDLE with a trigger): `shreg` <= `bin_in`, `last_bin` <= `bin_in`, scratch BCD <= 0, `cnt` <= WIDTH−1, state <= SHIFT.
- Each SHIFT cycle:
  - Add 3 to every scratch digit that is >=5.
  - Shift {scratch, `shreg`} left by 1 bit; the `shreg` MSB enters scratch bit 0.
  - Decrement `cnt`.
- Final iteration (`cnt`==0): `bcd_out` <= the post-shift scratch, `done` <= 1, state <= IDLE.
- `bcd_out` changes only at that final edge or at reset.
- While SHIFT is active: `start` is ignored, changes to `auto_en` or `bin_in` have no effect, and no request is queued.
- A `start` in the cycle `done` is high (state is IDLE) is accepted.
- Arithmetic: the adjust uses 4-bit adds with no carry between digits. The DIGITS constraint guarantees no overflow.
- `busy` = (state==SHIFT), registered.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `bcd_out` 0, `last_bin` 0, `cnt` 0.
- `last_bin` resets to 0, consistent with `bcd_out`=0. With `auto_en`=1 and `bin_in`=0 after reset, no conversion starts.
- Trigger sampled at edge E0:
  - `busy`=1 after E0.
  - Shifts at edges E1..E_WIDTH.
  - At E_WIDTH: `bcd_out` valid, `done`=1 for exactly one cycle, `busy`=0.
  - Latency from trigger edge to `done` is WIDTH+1 edges: 17 for the defaults.
- Back-to-back throughput: one conversion per WIDTH+1 cycles.
- Reset mid-conversion (`rst_n`=0 at any edge):
  - Abort immediately and return all registers to reset values.
  - No `done` pulse.
  - `bcd_out` returns to 0.
- `start` and an auto trigger in the same cycle produce a single conversion.

## Configuration
- `SCORE_BCD_BLANK_EN` defined:
  - Adds output port `blank` [DIGITS−1:0].
  - Bit i=1 when digit i and all higher digits of the new result are 0.
  - Bit 0 is always 0, so a lone "0" still shows.
  - Registered and updated on the same edge as `bcd_out`; reset value {DIGITS−1{1}},0.
  - The SSD mux forces all cathodes high on blanked digits.
- Undefined: no `blank` port and no blanking logic; all digits display, including leading zeros.

## Test plan
- Reset, then `start` with `bin_in`=0 → `done` after 17 cycles, `bcd_out`=20'h00000; `blank`=5'b11110 if the macro is enabled.
- `bin_in`=65535, `start` pulse → `busy` high for 16 cycles, `done` on cycle 17, `bcd_out`=20'h65535, `blank`=5'b00000.
- `bin_in`=1234, `start` → `bcd_out`=20'h01234, `blank`=5'b10000. Then `start` again at cycle 5 with `bin_in`=99 → ignored; exactly one `done`; `bcd_out` still 20'h01234.
- `auto_en`=1, `bin_in` stepping 7→8→8 → exactly two conversions: `bcd_out` 20'h00007 then 20'h00008. No third conversion while `bin_in` is held at 8.
- `rst_n`=0 at cycle 10 of converting 4321 → no `done`, `bcd_out`=0, `busy`=0 the next cycle. A new `start` after release gives 20'h04321 at 17 cycles.
- `start` asserted in the cycle `done` is high with `bin_in`=500 → the second conversion runs back-to-back: `done` 17 cycles later, `bcd_out`=20'h00500.
